// File: rtl/disc_timing_pkg.sv
// Shared disc timing-track constants, word-position type and Z2/Z3 decode functions.
package disc_timing_pkg;

    localparam int unsigned WORD_BITS = 40;
    localparam int unsigned ADR_BITS  = 7;
    localparam int unsigned ADR_POS   = 32;
    localparam int unsigned BIT_W     = 6;
    localparam int unsigned ADR_IW    = $clog2(ADR_BITS);

    localparam int unsigned SYNC_A_LO = 31;
    localparam int unsigned SYNC_A_HI = 33;
    localparam int unsigned SYNC_B_LO = 38;
    localparam int unsigned SYNC_B_HI = 39;

    typedef logic [BIT_W-1:0]    bit_t;
    typedef logic [ADR_BITS-1:0] adr_t;

    typedef struct packed {
        bit_t bit_idx;
        adr_t adr;
    } word_pos_t;

    // Word-sync track value for bit time b.
    function automatic logic decode_z2(input bit_t b);
        return ((b >= BIT_W'(SYNC_A_LO)) && (b <= BIT_W'(SYNC_A_HI))) ||
               ((b >= BIT_W'(SYNC_B_LO)) && (b <= BIT_W'(SYNC_B_HI)));
    endfunction

    // Serial address track: address bits LSB first starting at ADR_POS, 0 elsewhere.
    function automatic logic decode_z3(input bit_t b, input adr_t adr);
        logic z;
        z = 1'b0;
        for (int unsigned i = 0; i < ADR_BITS; i++) begin
            if (b == BIT_W'(ADR_POS + i)) begin
                z = adr[ADR_IW'(i)];
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/disc_word_counter.sv
// Bit/word position counter: bit index within a word and sector address, with load and wrap.
module disc_word_counter
    import disc_timing_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    input  logic      ld,
    input  adr_t      adr_in,
    output word_pos_t pos,
    output word_pos_t pos_c
);

    word_pos_t pos_q;

    // Next position; clear beats load, load beats the word-end increment.
    always_comb begin
        pos_c = pos_q;
        if (clr) begin
            pos_c = '0;
        end else if (ld) begin
            pos_c.bit_idx = '0;
            pos_c.adr     = adr_in;
        end else if (pos_q.bit_idx == BIT_W'(WORD_BITS - 1)) begin
            pos_c.bit_idx = '0;
            pos_c.adr     = pos_q.adr + ADR_BITS'(1);
        end else if (pos_q.bit_idx >= BIT_W'(WORD_BITS)) begin
            pos_c.bit_idx = '0;
        end else begin
            pos_c.bit_idx = pos_q.bit_idx + BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_c;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/disc_timing_track_gen.sv
// Disc timing-track generator: emits Z2 word-sync and Z3 serial address aligned to BIT/ADR.
module disc_timing_track_gen
    import disc_timing_pkg::*;
(
    input  logic                Z1,
    input  logic                CLR,
    input  logic                ADR_LD,
    input  logic [ADR_BITS-1:0] ADR_IN,
    output logic                Z2,
    output logic                _Z2,
    output logic                Z3,
    output logic                _Z3,
    output logic [BIT_W-1:0]    BIT,
    output logic [ADR_BITS-1:0] ADR,
    output logic                WS,
    output logic                INDEX
);

    word_pos_t pos;
    word_pos_t pos_c;
    logic      z2_q;
    logic      nz2_q;
    logic      z3_q;
    logic      nz3_q;

    disc_word_counter u_counter (
        .clk    (Z1),
        .clr    (CLR),
        .ld     (ADR_LD),
        .adr_in (ADR_IN),
        .pos    (pos),
        .pos_c  (pos_c)
    );

    // Decode from the next position so the tracks line up with the BIT register.
    // Complements are separate flops fed from the same decode, so they never skew.
    always_ff @(posedge Z1) begin
        if (CLR) begin
            z2_q  <= 1'b0;
            nz2_q <= 1'b1;
            z3_q  <= 1'b0;
            nz3_q <= 1'b1;
        end else begin
            z2_q  <= decode_z2(pos_c.bit_idx);
            nz2_q <= ~decode_z2(pos_c.bit_idx);
            z3_q  <= decode_z3(pos_c.bit_idx, pos_c.adr);
            nz3_q <= ~decode_z3(pos_c.bit_idx, pos_c.adr);
        end
    end

    assign Z2    = z2_q;
    assign _Z2   = nz2_q;
    assign Z3    = z3_q;
    assign _Z3   = nz3_q;
    assign BIT   = pos.bit_idx;
    assign ADR   = pos.adr;
    assign WS    = (pos.bit_idx == '0);
    assign INDEX = (pos.bit_idx == '0) && (pos.adr == '0);

endmodule

// File: tb/tb_disc_timing_track_gen.sv
// Self-checking bench for disc_timing_track_gen against an arithmetic bit/word model.
module tb_disc_timing_track_gen;

    logic       Z1;
    logic       CLR;
    logic       ADR_LD;
    logic [6:0] ADR_IN;
    logic       Z2;
    logic       _Z2;
    logic       Z3;
    logic       _Z3;
    logic [5:0] BIT;
    logic [6:0] ADR;
    logic       WS;
    logic       INDEX;

    int errors  = 0;
    int checks  = 0;
    int m_bit   = 0;
    int m_adr   = 0;
    bit started = 1'b0;

    disc_timing_track_gen dut (
        .Z1     (Z1),
        .CLR    (CLR),
        .ADR_LD (ADR_LD),
        .ADR_IN (ADR_IN),
        .Z2     (Z2),
        ._Z2    (_Z2),
        .Z3     (Z3),
        ._Z3    (_Z3),
        .BIT    (BIT),
        .ADR    (ADR),
        .WS     (WS),
        .INDEX  (INDEX)
    );

    initial Z1 = 1'b0;
    always #5 Z1 = ~Z1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (bit=%0d adr=%0d)", tag, obs, exp, m_bit, m_adr);
        end
    endtask

    // Complements must be exact inverses in every cycle once reset has been applied.
    always @(negedge Z1) begin
        if (started) begin
            checks++;
            assert ((_Z2 === ~Z2) && (_Z3 === ~Z3) && (Z2 !== 1'bx) && (Z3 !== 1'bx)) else begin
                errors++;
                $error("FAIL complement: Z2=%b _Z2=%b Z3=%b _Z3=%b", Z2, _Z2, Z3, _Z3);
            end
        end
    end

    function automatic int exp_z2(input int b);
        return ((b >= 31 && b <= 33) || (b >= 38 && b <= 39)) ? 1 : 0;
    endfunction

    function automatic int exp_z3(input int b, input int a);
        return (b >= 32 && b <= 38) ? ((a >> (b - 32)) & 1) : 0;
    endfunction

    // One Z1 cycle: drive, advance the model by the track rules, then compare.
    task automatic step(input logic c, input logic l, input int ain);
        CLR    = c;
        ADR_LD = l;
        ADR_IN = 7'(ain);
        @(posedge Z1);
        if (c) begin
            m_bit = 0;
            m_adr = 0;
        end else if (l) begin
            m_bit = 0;
            m_adr = ain % 128;
        end else if (m_bit == 39) begin
            m_bit = 0;
            m_adr = (m_adr + 1) % 128;
        end else begin
            m_bit = m_bit + 1;
        end
        #1;
        CLR    = 1'b0;
        ADR_LD = 1'b0;
        check("BIT", 32'(BIT), 32'(m_bit));
        check("ADR", 32'(ADR), 32'(m_adr));
        check("Z2", 32'(Z2), 32'(exp_z2(m_bit)));
        check("Z3", 32'(Z3), 32'(exp_z3(m_bit, m_adr)));
        check("WS", 32'(WS), 32'(m_bit == 0));
        check("INDEX", 32'(INDEX), 32'((m_bit == 0) && (m_adr == 0)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic run_to(input int b);
        for (int i = 0; i < 45 && m_bit != b; i++) step(1'b0, 1'b0, 0);
        check("run_to", 32'(BIT), 32'(b));
    endtask

    initial begin
        int gap;
        bool_wait: begin end
        CLR    = 1'b0;
        ADR_LD = 1'b0;
        ADR_IN = '0;

        // Reset, then one clean word and a second word at ADR=1.
        step(1'b1, 1'b0, 0);
        started = 1'b1;
        step(1'b1, 1'b1, 5);
        run(80);

        // Load 0x55 mid-word, observe its address bits and the following word.
        run_to(17);
        step(1'b0, 1'b1, 'h55);
        check("load55_adr", 32'(ADR), 32'h55);
        run(80);

        // Load 0x7F, wrap to 0, then time a full revolution between INDEX pulses.
        step(1'b0, 1'b1, 'h7F);
        gap = 0;
        for (int i = 0; i < 100 && !INDEX; i++) step(1'b0, 1'b0, 0);
        check("wrap_index", 32'(INDEX), 32'd1);
        step(1'b0, 1'b0, 0);
        check("index_pulse_width", 32'(INDEX), 32'd0);
        gap = 1;
        for (int i = 0; i < 6000 && !INDEX; i++) begin
            step(1'b0, 1'b0, 0);
            gap++;
        end
        check("revolution_cycles", 32'(gap), 32'd5120);

        // Load on the word-end edge wins over the increment.
        run(3);
        run_to(39);
        step(1'b0, 1'b1, 'h2A);
        check("load_at_wrap", 32'(ADR), 32'h2A);

        // Clear wins over a simultaneous load.
        run(10);
        step(1'b1, 1'b1, 'h33);
        check("clr_over_ld", 32'(ADR), 32'd0);

        // Clear in the middle of the first sync window.
        step(1'b0, 1'b1, 'h6B);
        run_to(33);
        check("z2_before_clr", 32'(Z2), 32'd1);
        step(1'b1, 1'b0, 0);
        check("z2_after_clr", 32'(Z2), 32'd0);

        // Randomised loads and clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0), int'($urandom_range(0, 127)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
